// File: rtl/water_tank_pkg.sv
// -----------------------------------------------------------------------------
// water_tank_pkg
// Purpose: shared constants for the tank level decoder/valve controller.
//   - 2-bit level codes as produced by the tank level encoder
//   - valve controller FSM state encodings
//   - helper turning a level code into a one-hot flag vector
// Ports: none (package).
// -----------------------------------------------------------------------------
package water_tank_pkg;

    localparam int LVL_W = 2;

    localparam logic [LVL_W-1:0] LVL_EMPTY  = 2'b00;
    localparam logic [LVL_W-1:0] LVL_LOW    = 2'b01;
    localparam logic [LVL_W-1:0] LVL_MEDIUM = 2'b10;
    localparam logic [LVL_W-1:0] LVL_FULL   = 2'b11;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'b00;
    localparam logic [ST_W-1:0] ST_FILLING = 2'b01;
    localparam logic [ST_W-1:0] ST_FAULT   = 2'b10;

    // Bit n of the result is set for level code n (bit0 EMPTY .. bit3 FULL).
    function automatic logic [3:0] level_onehot(input logic [LVL_W-1:0] lvl);
        level_onehot = 4'b0001 << lvl;
    endfunction

endpackage

// File: rtl/level_code_debouncer.sv
// -----------------------------------------------------------------------------
// level_code_debouncer
// Purpose: brings the asynchronous 2-bit level code into the clock domain with
//   a two-flop synchroniser, then only accepts a code once it has been seen
//   unchanged for DEBOUNCE_CYCLES synchronised cycles.
// Ports:
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous active-high reset
//   level_code_i    in   raw level code (asynchronous to clk_i)
//   stable_level_o  out  accepted (stable) level, registered
//   stable_next_o   out  value stable_level_o takes at the next edge
//   update_o        out  one-cycle pulse, high in the cycle the stable level changed
// -----------------------------------------------------------------------------
module level_code_debouncer
    import water_tank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LVL_W-1:0] level_code_i,
    output logic [LVL_W-1:0] stable_level_o,
    output logic [LVL_W-1:0] stable_next_o,
    output logic             update_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [LVL_W-1:0] sync1_q, sync1_d;
    logic [LVL_W-1:0] sync2_q, sync2_d;
    logic [LVL_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] stable_q, stable_d;
    logic             update_q, update_d;
    logic             accept;

    always_comb begin
        sync1_d = level_code_i;
        sync2_d = sync1_q;

        cand_d = cand_q;
        cnt_d  = cnt_q;
        // Any change of the synchronised code restarts the hold count; the
        // count saturates so a long-held code does not wrap.
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        accept   = (cnt_q == CNT_MAX) && (cand_q != stable_q);
        stable_d = accept ? cand_q : stable_q;
        update_d = accept;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= LVL_EMPTY;
            sync2_q  <= LVL_EMPTY;
            cand_q   <= LVL_EMPTY;
            cnt_q    <= '0;
            stable_q <= LVL_EMPTY;
            update_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            update_q <= update_d;
        end
    end

    assign stable_level_o = stable_q;
    assign stable_next_o  = stable_d;
    assign update_o       = update_q;

endmodule

// File: rtl/water_level_decoder_ctrl.sv
// -----------------------------------------------------------------------------
// water_level_decoder_ctrl
// Purpose: consumes the tank level encoder's 2-bit code, debounces it, decodes
//   it to one-hot level flags and drives the fill valve with hysteresis and a
//   no-progress timeout that latches a fault alarm.
// Ports:
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous active-high reset
//   level_code_i    in   raw level code (00 EMPTY, 01 LOW, 10 MEDIUM, 11 FULL)
//   enable_i        in   automatic filling allowed
//   clear_fault_i   in   leaves FAULT back to IDLE
//   level_empty_o   out  stable level is EMPTY
//   level_low_o     out  stable level is LOW
//   level_medium_o  out  stable level is MEDIUM
//   level_full_o    out  stable level is FULL
//   level_update_o  out  one-cycle pulse when the stable level changes
//   valve_o         out  fill valve open
//   alarm_o         out  fault latched
// -----------------------------------------------------------------------------
module water_level_decoder_ctrl
    import water_tank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FILL_TIMEOUT    = 1000,
    parameter int TIMEOUT_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] level_code_i,
    input  logic       enable_i,
    input  logic       clear_fault_i,
    output logic       level_empty_o,
    output logic       level_low_o,
    output logic       level_medium_o,
    output logic       level_full_o,
    output logic       level_update_o,
    output logic       valve_o,
    output logic       alarm_o
);

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(FILL_TIMEOUT - 1);

    logic [LVL_W-1:0]     stable_level;
    logic [LVL_W-1:0]     stable_next;
    logic                 level_update;
    logic [LVL_W-1:0]     prev_level_q, prev_level_d;
    logic [3:0]           flags_q, flags_d;
    logic [ST_W-1:0]      state_q, state_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic                 valve_q, valve_d;
    logic                 alarm_q, alarm_d;
    logic                 level_rise;

    level_code_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .level_code_i   (level_code_i),
        .stable_level_o (stable_level),
        .stable_next_o  (stable_next),
        .update_o       (level_update)
    );

    always_comb begin
        // Flags are registered from the debouncer's next value so they change
        // on the same edge as the stable level itself.
        flags_d = level_onehot(stable_next);

        // The stable level only moves together with the update pulse, so the
        // value held here during the pulse is the level before the change.
        prev_level_d = stable_level;
        level_rise   = level_update && (stable_level > prev_level_q);

        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                // Hysteresis: only LOW or EMPTY starts a fill.
                if (enable_i && (stable_level <= LVL_LOW)) begin
                    state_d = ST_FILLING;
                    timer_d = '0;
                end
            end
            ST_FILLING: begin
                if (stable_level == LVL_FULL) begin
                    state_d = ST_IDLE;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (level_rise) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (clear_fault_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valve_d = (state_d == ST_FILLING);
        alarm_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q      <= level_onehot(LVL_EMPTY);
            prev_level_q <= LVL_EMPTY;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            valve_q      <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            prev_level_q <= prev_level_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            valve_q      <= valve_d;
            alarm_q      <= alarm_d;
        end
    end

    assign level_empty_o  = flags_q[0];
    assign level_low_o    = flags_q[1];
    assign level_medium_o = flags_q[2];
    assign level_full_o   = flags_q[3];
    assign level_update_o = level_update;
    assign valve_o        = valve_q;
    assign alarm_o        = alarm_q;

endmodule

// File: tb/tb_water_level_decoder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_water_level_decoder_ctrl
// Purpose: self-checking bench for water_level_decoder_ctrl with
//   DEBOUNCE_CYCLES=4 and FILL_TIMEOUT=20. Directed scenarios followed by a
//   randomized phase, all compared cycle by cycle against a reference model.
// -----------------------------------------------------------------------------
module tb_water_level_decoder_ctrl;

    localparam int DEB = 4;
    localparam int TO  = 20;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] level_code_i;
    logic       enable_i;
    logic       clear_fault_i;
    logic       level_empty_o;
    logic       level_low_o;
    logic       level_medium_o;
    logic       level_full_o;
    logic       level_update_o;
    logic       valve_o;
    logic       alarm_o;

    always #5 clk = ~clk;

    water_level_decoder_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .FILL_TIMEOUT    (TO),
        .TIMEOUT_W       (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .level_code_i   (level_code_i),
        .enable_i       (enable_i),
        .clear_fault_i  (clear_fault_i),
        .level_empty_o  (level_empty_o),
        .level_low_o    (level_low_o),
        .level_medium_o (level_medium_o),
        .level_full_o   (level_full_o),
        .level_update_o (level_update_o),
        .valve_o        (valve_o),
        .alarm_o        (alarm_o)
    );

    int n_cmp     = 0;
    int n_bad     = 0;
    int upd_seen  = 0;
    int valve_cnt = 0;
    logic got_alarm;

    // ---------------- reference model ----------------
    // Level: accepted once the last DEB synchronised samples agree and differ
    // from the current level. Synchronised sample at edge n is the raw sample
    // from edge n-2; acceptance at edge n uses raw samples n-DEB-2 .. n-3.
    int m_level;
    int m_old;
    bit m_upd;
    bit m_fill;
    bit m_fault;
    int m_timer;
    int hist[$];

    task automatic model_reset();
        m_level = 0;
        m_old   = 0;
        m_upd   = 1'b0;
        m_fill  = 1'b0;
        m_fault = 1'b0;
        m_timer = 0;
        hist    = {};
        for (int i = 0; i < DEB + 3; i++) hist.push_back(0);
    endtask

    task automatic model_step();
        bit run_ok;
        if (m_fault) begin
            if (clear_fault_i) m_fault = 1'b0;
        end else if (m_fill) begin
            if (m_level == 3)                   m_fill = 1'b0;
            else if (!enable_i)                 m_fill = 1'b0;
            else if (m_upd && m_level > m_old)  m_timer = 0;
            else if (m_timer == TO - 1) begin
                m_fill  = 1'b0;
                m_fault = 1'b1;
            end else                            m_timer = m_timer + 1;
        end else if (enable_i && m_level <= 1) begin
            m_fill  = 1'b1;
            m_timer = 0;
        end

        hist.push_back(int'(level_code_i));
        void'(hist.pop_front());
        run_ok = 1'b1;
        for (int i = 1; i < DEB; i++) if (hist[i] != hist[0]) run_ok = 1'b0;
        m_upd = 1'b0;
        if (run_ok && hist[0] != m_level) begin
            m_old   = m_level;
            m_level = hist[0];
            m_upd   = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) model_reset();
        else       model_step();
    end

    // ---------------- comparison helpers ----------------
    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("flag_empty",  level_empty_o,  m_level == 0);
        chk("flag_low",    level_low_o,    m_level == 1);
        chk("flag_medium", level_medium_o, m_level == 2);
        chk("flag_full",   level_full_o,   m_level == 3);
        chk("update",      level_update_o, m_upd);
        chk("valve",       valve_o,        m_fill);
        chk("alarm",       alarm_o,        m_fault);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
            if (level_update_o) upd_seen++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i         = 1'b1;
        level_code_i  = 2'b00;
        enable_i      = 1'b0;
        clear_fault_i = 1'b0;
        cyc(3);
        chk("rst_empty", level_empty_o, 1'b1);
        chk("rst_full",  level_full_o,  1'b0);
        chk("rst_valve", valve_o,       1'b0);
        chk("rst_alarm", alarm_o,       1'b0);
        rst_i    = 1'b0;
        enable_i = 1'b1;

        // 1: fill from EMPTY through LOW, MEDIUM to FULL
        cyc(1);
        chk("t1_valve_open", valve_o, 1'b1);
        upd_seen     = 0;
        level_code_i = 2'b01;
        cyc(6); chk("t1_low_early",  level_low_o, 1'b0);
        cyc(1); chk("t1_low_edge7",  level_low_o, 1'b1);
        cyc(3);
        level_code_i = 2'b10;
        cyc(6); chk("t1_med_early",  level_medium_o, 1'b0);
        cyc(1); chk("t1_med_edge7",  level_medium_o, 1'b1);
        cyc(3);
        level_code_i = 2'b11;
        cyc(6); chk("t1_full_early", level_full_o, 1'b0);
        cyc(1); chk("t1_full_edge7", level_full_o, 1'b1);
        chk("t1_valve_still_open", valve_o, 1'b1);
        cyc(1); chk("t1_valve_closed", valve_o, 1'b0);
        cyc(2);
        chk_int("t1_update_pulses", upd_seen, 3);

        // 2: glitch rejection and hysteresis
        cyc(4);
        upd_seen     = 0;
        level_code_i = 2'b10;
        cyc(2);
        level_code_i = 2'b11;
        cyc(10);
        chk_int("t2_glitch_updates", upd_seen, 0);
        chk("t2_full_kept", level_full_o, 1'b1);
        level_code_i = 2'b10;
        cyc(12);
        chk("t2_medium", level_medium_o, 1'b1);
        chk("t2_no_refill_medium", valve_o, 1'b0);
        level_code_i = 2'b11;
        cyc(12);
        chk("t2_no_refill_full", valve_o, 1'b0);

        // 3: no progress -> fault, enable ignored, clear restarts
        level_code_i = 2'b01;
        valve_cnt    = 0;
        got_alarm    = 1'b0;
        for (int i = 0; i < 80 && !got_alarm; i++) begin
            cyc(1);
            if (alarm_o)      got_alarm = 1'b1;
            else if (valve_o) valve_cnt++;
        end
        chk("t3_alarm_reached", got_alarm, 1'b1);
        chk_int("t3_fill_cycles", valve_cnt, TO);
        chk("t3_valve_closed", valve_o, 1'b0);
        enable_i = 1'b0;
        cyc(3);
        enable_i = 1'b1;
        cyc(3);
        chk("t3_alarm_held", alarm_o, 1'b1);
        chk("t3_valve_held", valve_o, 1'b0);
        clear_fault_i = 1'b1;
        cyc(1);
        clear_fault_i = 1'b0;
        chk("t3_alarm_cleared", alarm_o, 1'b0);
        cyc(1);
        chk("t3_refill", valve_o, 1'b1);

        // 4: steady rises keep the timer from expiring
        level_code_i = 2'b10;
        cyc(15);
        level_code_i = 2'b11;
        cyc(15);
        chk("t4_full",     level_full_o, 1'b1);
        chk("t4_no_alarm", alarm_o,      1'b0);
        chk("t4_closed",   valve_o,      1'b0);

        // 5: enable drop closes, enable return reopens at LOW
        level_code_i = 2'b01;
        cyc(10);
        chk("t5_filling", valve_o, 1'b1);
        enable_i = 1'b0;
        cyc(1);
        chk("t5_disable_close", valve_o, 1'b0);
        enable_i = 1'b1;
        cyc(1);
        chk("t5_reopen", valve_o, 1'b1);

        // 6: asynchronous reset mid-fill
        cyc(3);
        @(posedge clk);
        #3 rst_i = 1'b1;
        #1;
        chk("t6_async_valve", valve_o,        1'b0);
        chk("t6_async_empty", level_empty_o,  1'b1);
        chk("t6_async_low",   level_low_o,    1'b0);
        chk("t6_async_alarm", alarm_o,        1'b0);
        chk("t6_async_upd",   level_update_o, 1'b0);
        cyc(3);
        chk("t6_hold_valve", valve_o,       1'b0);
        chk("t6_hold_empty", level_empty_o, 1'b1);
        rst_i = 1'b0;
        cyc(12);

        // randomized phase
        for (int k = 0; k < 60; k++) begin
            level_code_i  = 2'($urandom_range(0, 3));
            enable_i      = ($urandom_range(0, 9) != 0);
            clear_fault_i = ($urandom_range(0, 5) == 0);
            cyc(int'($urandom_range(1, 12)));
        end
        clear_fault_i = 1'b0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
